hub75_rx: RTL and testbench

Receive-side HUB75 decoder: samples a HUB75 panel bus (shift clock, latch, output enable, row select, dual RGB lanes) driven by an external or looped-back driver, rebuilds full-depth pixels from `bpp_p` bit-planes, and writes them through a framebuffer write port (address, packed `{R,G,B}` pixel, write enable). It closes the loop for panel-chain emulation and for self-checking display benches. A frame-done pulse and error flags report bus health.

---
 rtl/hub75_pkg.sv | 20 ++
 rtl/hub75_rx_sync.sv | 35 +++
 rtl/hub75_rx.sv | 257 +++++++++++++++++++++++++
 tb/tb_hub75_rx.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 receive decoder.
`timescale 1ns/1ps
package hub75_pkg;

  localparam int unsigned HUB75_BPP  = 8;
  localparam int unsigned HUB75_SEGS = 2;

  typedef struct packed {
    logic [HUB75_BPP-1:0] r;
    logic [HUB75_BPP-1:0] g;
    logic [HUB75_BPP-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    HUB75_IDLE  = 2'd0,
    HUB75_SHIFT = 2'd1,
    HUB75_FLUSH = 2'd2
  } hub75_rx_state_e;

endpackage

// File: rtl/hub75_rx_sync.sv
// Two-flop synchroniser bank; the low EW bits also get a rising-edge detect.
`timescale 1ns/1ps
module hub75_rx_sync
  import hub75_pkg::*;
#(
  parameter int unsigned W  = 2,
  parameter int unsigned EW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    i_async,
  output logic [W-EW-1:0] o_level,
  output logic [EW-1:0]   o_rise_c
);

  logic [W-1:0]  r_s1;
  logic [W-1:0]  r_s2;
  logic [EW-1:0] r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2[EW-1:0];
    end
  end

  assign o_level  = r_s2[W-1:EW];
  assign o_rise_c = r_s2[EW-1:0] & ~r_s3;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 receive decoder: rebuilds bit-planes into pixels and writes a framebuffer.
// Optional statistics counters are enabled by defining HUB75_RX_STATS_EN.
`timescale 1ns/1ps
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int unsigned hpixel_p = 64,
  parameter int unsigned vpixel_p = 64,
  parameter int unsigned bpp_p    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_enable,
  input  logic                                  i_hub_clk,
  input  logic                                  i_stb,
  input  logic                                  i_oe,
  input  logic [$clog2(vpixel_p/2)-1:0]         i_row,
  input  logic [2:0]                            i_rgb1,
  input  logic [2:0]                            i_rgb2,
  output logic [$clog2(hpixel_p*vpixel_p)-1:0]  o_wr_addr,
  output logic [3*bpp_p-1:0]                    o_wr_data,
  output logic                                  o_wr_en,
  output logic                                  o_frame_done,
`ifdef HUB75_RX_STATS_EN
  output logic [15:0]                           o_len_err_cnt,
  output logic [15:0]                           o_row_err_cnt,
  output logic [15:0]                           o_overrun_cnt,
  output logic [31:0]                           o_oe_cycles,
`endif
  output logic                                  o_err
);

  localparam int unsigned ROW_W   = $clog2(vpixel_p/HUB75_SEGS);
  localparam int unsigned ADDR_W  = $clog2(hpixel_p*vpixel_p);
  localparam int unsigned HC_W    = $clog2(hpixel_p);
  localparam int unsigned COL_W   = $clog2(hpixel_p+2);
  localparam int unsigned PLANE_W = $clog2(bpp_p);
  localparam int unsigned FL_W    = $clog2(HUB75_SEGS*hpixel_p);
  localparam int unsigned LANE_W  = 6;
`ifdef HUB75_RX_STATS_EN
  localparam int unsigned LVL_W   = ROW_W + LANE_W + 1;
`else
  localparam int unsigned LVL_W   = ROW_W + LANE_W;
`endif

  localparam logic [1:0] S_IDLE  = HUB75_IDLE;
  localparam logic [1:0] S_SHIFT = HUB75_SHIFT;
  localparam logic [1:0] S_FLUSH = HUB75_FLUSH;

  localparam logic [COL_W-1:0]   COL_FULL   = COL_W'(hpixel_p);
  localparam logic [COL_W-1:0]   COL_SAT    = COL_W'(hpixel_p+1);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(bpp_p-1);
  localparam logic [FL_W-1:0]    FL_LAST    = FL_W'(HUB75_SEGS*hpixel_p-1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(vpixel_p/HUB75_SEGS-1);

  logic [LVL_W-1:0]   w_level;
  logic [1:0]         w_rise;
  logic               w_hub_rise;
  logic               w_stb_rise;
  logic [ROW_W-1:0]   w_row;
  logic [2:0]         w_rgb1;
  logic [2:0]         w_rgb2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [PLANE_W-1:0] r_plane_cnt;
  logic [COL_W-1:0]   r_col_cnt;
  logic [ROW_W-1:0]   r_cur_row;
  logic [FL_W-1:0]    r_flush_cnt;
  logic               r_wr_en;
  logic               r_wr_last;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [3*bpp_p-1:0] r_wr_data;
  logic               r_frame_done;
  logic               r_err;

  logic               w_store;
  logic [PLANE_W-1:0] w_store_idx;
  logic               w_len_err;
  logic               w_row_err;
  logic               w_overrun;

  logic [LANE_W-1:0]  r_shift [hpixel_p];
  logic [LANE_W-1:0]  r_plane [bpp_p][hpixel_p];

  logic               w_seg;
  logic [HC_W-1:0]    w_col;
  logic [ADDR_W-1:0]  w_addr;
  logic [bpp_p-1:0]   w_r;
  logic [bpp_p-1:0]   w_g;
  logic [bpp_p-1:0]   w_b;

`ifdef HUB75_RX_STATS_EN
  logic               w_oe;
  hub75_rx_sync #(.W(LVL_W+2), .EW(2)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .i_async  ({i_row, i_rgb1, i_rgb2, i_oe, i_stb, i_hub_clk}),
    .o_level  (w_level),
    .o_rise_c (w_rise)
  );
  assign {w_row, w_rgb1, w_rgb2, w_oe} = w_level;
`else
  logic               w_unused_oe;
  assign w_unused_oe = i_oe;
  hub75_rx_sync #(.W(LVL_W+2), .EW(2)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .i_async  ({i_row, i_rgb1, i_rgb2, i_stb, i_hub_clk}),
    .o_level  (w_level),
    .o_rise_c (w_rise)
  );
  assign {w_row, w_rgb1, w_rgb2} = w_level;
`endif

  assign w_hub_rise = w_rise[0];
  assign w_stb_rise = w_rise[1];

  // Next state plus latch decisions; a row-change restarts the row at plane 0.
  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_store_idx = '0;
    w_len_err   = 1'b0;
    w_row_err   = 1'b0;
    w_overrun   = 1'b0;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_SHIFT;
        S_SHIFT: begin
          if (w_stb_rise) begin
            if (r_col_cnt != COL_FULL) begin
              w_len_err = 1'b1;
            end else begin
              w_store = 1'b1;
              if (r_plane_cnt != '0 && w_row != r_cur_row) begin
                w_row_err = 1'b1;
              end else begin
                w_store_idx = r_plane_cnt;
                if (r_plane_cnt == PLANE_LAST) w_state_nxt = S_FLUSH;
              end
            end
          end
        end
        S_FLUSH: begin
          w_overrun = w_stb_rise;
          if (r_flush_cnt == FL_LAST) w_state_nxt = S_SHIFT;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Flush read-out: segment 0 columns first, then segment 1.
  always_comb begin
    w_seg  = r_flush_cnt[FL_W-1];
    w_col  = r_flush_cnt[HC_W-1:0];
    w_addr = {w_seg, r_cur_row, w_col};
    w_r    = '0;
    w_g    = '0;
    w_b    = '0;
    for (int k = 0; k < int'(bpp_p); k++) begin
      w_r[k] = w_seg ? r_plane[k][w_col][2] : r_plane[k][w_col][5];
      w_g[k] = w_seg ? r_plane[k][w_col][1] : r_plane[k][w_col][4];
      w_b[k] = w_seg ? r_plane[k][w_col][0] : r_plane[k][w_col][3];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_plane_cnt  <= '0;
      r_col_cnt    <= '0;
      r_cur_row    <= '0;
      r_flush_cnt  <= '0;
      r_wr_en      <= 1'b0;
      r_wr_last    <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_en      <= 1'b0;
      r_wr_last    <= 1'b0;
      r_frame_done <= r_wr_en & r_wr_last;
      if (w_len_err || w_row_err || w_overrun) r_err <= 1'b1;
      if (r_state == S_IDLE) begin
        r_plane_cnt <= '0;
        r_col_cnt   <= '0;
        r_cur_row   <= '0;
        r_flush_cnt <= '0;
      end else begin
        if (w_stb_rise) begin
          r_col_cnt <= '0;
        end else if (w_hub_rise && r_col_cnt != COL_SAT) begin
          r_col_cnt <= r_col_cnt + COL_W'(1);
        end
        if (w_store) begin
          r_plane_cnt <= (w_store_idx == PLANE_LAST) ? '0 : w_store_idx + PLANE_W'(1);
          if (w_store_idx == '0) r_cur_row <= w_row;
        end
        if (r_state == S_FLUSH) begin
          r_wr_en     <= 1'b1;
          r_wr_addr   <= w_addr;
          r_wr_data   <= {w_r, w_g, w_b};
          r_wr_last   <= (r_flush_cnt == FL_LAST) && (r_cur_row == ROW_LAST);
          r_flush_cnt <= r_flush_cnt + FL_W'(1);
        end
      end
    end
  end

  // Shift register: newest lane pair enters column 0, oldest ends at the top column.
  always_ff @(posedge clk) begin
    if (r_state != S_IDLE && w_hub_rise) begin
      r_shift[0] <= {w_rgb1, w_rgb2};
      for (int c = 1; c < int'(hpixel_p); c++) r_shift[c] <= r_shift[c-1];
    end
    if (w_store) r_plane[w_store_idx] <= r_shift;
  end

`ifdef HUB75_RX_STATS_EN
  logic [15:0] r_len_err_cnt;
  logic [15:0] r_row_err_cnt;
  logic [15:0] r_overrun_cnt;
  logic [31:0] r_oe_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_err_cnt <= '0;
      r_row_err_cnt <= '0;
      r_overrun_cnt <= '0;
      r_oe_cycles   <= '0;
    end else begin
      if (w_len_err && r_len_err_cnt != 16'hFFFF) r_len_err_cnt <= r_len_err_cnt + 16'd1;
      if (w_row_err && r_row_err_cnt != 16'hFFFF) r_row_err_cnt <= r_row_err_cnt + 16'd1;
      if (w_overrun && r_overrun_cnt != 16'hFFFF) r_overrun_cnt <= r_overrun_cnt + 16'd1;
      if (!w_oe) r_oe_cycles <= r_oe_cycles + 32'd1;
    end
  end

  assign o_len_err_cnt = r_len_err_cnt;
  assign o_row_err_cnt = r_row_err_cnt;
  assign o_overrun_cnt = r_overrun_cnt;
  assign o_oe_cycles   = r_oe_cycles;
`endif

  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_wr_en      = r_wr_en;
  assign o_frame_done = r_frame_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_hub75_rx.sv
// Scoreboard bench for hub75_rx: drives HUB75 planes, checks framebuffer writes.
`timescale 1ns/1ps
module tb_hub75_rx;
  import hub75_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_enable;
  logic        i_hub_clk;
  logic        i_stb;
  logic        i_oe;
  logic [4:0]  i_row;
  logic [2:0]  i_rgb1;
  logic [2:0]  i_rgb2;
  logic [11:0] o_wr_addr;
  logic [23:0] o_wr_data;
  logic        o_wr_en;
  logic        o_frame_done;
  logic        o_err;
`ifdef HUB75_RX_STATS_EN
  logic [15:0] o_len_err_cnt;
  logic [15:0] o_row_err_cnt;
  logic [15:0] o_overrun_cnt;
  logic [31:0] o_oe_cycles;
`endif

  hub75_rx dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (i_enable),
    .i_hub_clk     (i_hub_clk),
    .i_stb         (i_stb),
    .i_oe          (i_oe),
    .i_row         (i_row),
    .i_rgb1        (i_rgb1),
    .i_rgb2        (i_rgb2),
    .o_wr_addr     (o_wr_addr),
    .o_wr_data     (o_wr_data),
    .o_wr_en       (o_wr_en),
    .o_frame_done  (o_frame_done),
`ifdef HUB75_RX_STATS_EN
    .o_len_err_cnt (o_len_err_cnt),
    .o_row_err_cnt (o_row_err_cnt),
    .o_overrun_cnt (o_overrun_cnt),
    .o_oe_cycles   (o_oe_cycles),
`endif
    .o_err         (o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_wr    = 0;
  int          n_fd    = 0;
  logic [35:0] sb [$];
  logic [23:0] img [2][64];
  logic        prev_en   = 1'b0;
  logic [11:0] prev_addr = '0;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop the expected write on every strobe; frame_done must follow the last frame write.
  always @(negedge clk) begin
    if (o_frame_done) begin
      n_fd++;
      n_tests++;
      if (!(prev_en && prev_addr == 12'd4095)) begin
        n_fail++;
        $display("FAIL frame_done_pos: prev_en=%0b prev_addr=%0d expected prev_en=1 prev_addr=4095",
                 prev_en, prev_addr);
      end
    end
    if (o_wr_en) begin
      logic [35:0] exp;
      n_wr++;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: addr=%0d data=%06h expected no write", o_wr_addr, o_wr_data);
      end else begin
        exp = sb.pop_front();
        if ({o_wr_addr, o_wr_data} !== exp) begin
          n_fail++;
          $display("FAIL wr_data: addr=%0d data=%06h expected addr=%0d data=%06h",
                   o_wr_addr, o_wr_data, exp[35:24], exp[23:0]);
        end
      end
    end
    prev_en   = o_wr_en;
    prev_addr = o_wr_addr;
  end

  function automatic logic [23:0] pat(input int row, input int seg, input int col, input int salt);
    rgb_t p;
    p.r = 8'(col * 7 + row + salt);
    p.g = 8'(row * 5 + seg * 100 + 1);
    p.b = 8'(col + seg * 64 + row * 3 + salt * 11);
    return p;
  endfunction

  task automatic fill_pat(input int row, input int salt);
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 64; c++) img[s][c] = pat(row, s, c, salt);
  endtask

  task automatic fill_single();
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 64; c++) img[s][c] = 24'h0;
    img[0][3] = 24'hA53CFF;
  endtask

  task automatic push_row(input int row, input int n);
    for (int i = 0; i < n; i++) begin
      int s;
      int c;
      s = i / 64;
      c = i % 64;
      sb.push_back({12'((row + s * 32) * 64 + c), img[s][c]});
    end
  endtask

  task automatic latch(input int row);
    i_row = 5'(row);
    #20 i_stb = 1'b1;
    #20 i_stb = 1'b0;
    #20;
  endtask

  // First column shifted is column 63.
  task automatic send_plane(input int k, input int row, input int ncols);
    for (int i = 0; i < ncols; i++) begin
      logic [23:0] p0;
      logic [23:0] p1;
      p0 = img[0][63-i];
      p1 = img[1][63-i];
      i_rgb1 = {p0[16+k], p0[8+k], p0[k]};
      i_rgb2 = {p1[16+k], p1[8+k], p1[k]};
      #20 i_hub_clk = 1'b1;
      #20 i_hub_clk = 1'b0;
    end
    latch(row);
  endtask

  task automatic send_row(input int row);
    for (int k = 0; k < 8; k++) send_plane(k, row, 64);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 800 && sb.size() != 0; i++) @(negedge clk);
    check(name, 36'(sb.size()), 36'd0);
    sb.delete();
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int wr0;
    int fd0;
    rst       = 1'b1;
    i_enable  = 1'b0;
    i_hub_clk = 1'b0;
    i_stb     = 1'b0;
    i_oe      = 1'b1;
    i_row     = '0;
    i_rgb1    = '0;
    i_rgb2    = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_en",      36'(o_wr_en),      36'd0);
    check("rst_frame_done", 36'(o_frame_done), 36'd0);
    check("rst_err",        36'(o_err),        36'd0);
    check("rst_wr_addr",    36'(o_wr_addr),    36'd0);
    check("rst_wr_data",    36'(o_wr_data),    36'd0);
    @(negedge clk);
    rst      = 1'b0;
    i_enable = 1'b1;
    repeat (2) @(negedge clk);

`ifdef HUB75_RX_STATS_EN
    begin
      logic [31:0] oe0;
      repeat (4) @(negedge clk);
      oe0 = o_oe_cycles;
      i_oe = 1'b0;
      #200 i_oe = 1'b1;
      repeat (5) @(negedge clk);
      check("oe_cycles", 36'(o_oe_cycles - oe0), 36'd20);
    end
`endif

    // Full frame; row 5 carries the single-pixel pattern.
    fd0 = n_fd;
    for (int row = 0; row < 32; row++) begin
      if (row == 5) begin
        wait_drain("drain_pre_row5");
        fill_single();
      end else begin
        fill_pat(row, 0);
      end
      push_row(row, 128);
      wr0 = n_wr;
      send_row(row);
      if (row == 5) begin
        wait_drain("drain_row5");
        check("row5_writes", 36'(n_wr - wr0), 36'd128);
        check("row5_err",    36'(o_err),      36'd0);
      end
    end
    wait_drain("drain_frame");
    check("frame_done_count", 36'(n_fd - fd0), 36'd1);
    check("frame_err",        36'(o_err),      36'd0);

    // Short latch: 63 columns.
    pulse_rst();
    fill_pat(12, 3);
    wr0 = n_wr;
    send_plane(0, 12, 63);
    repeat (6) @(negedge clk);
    #1;
    check("len_err_flag",   36'(o_err),       36'd1);
    check("len_err_no_wr",  36'(n_wr - wr0),  36'd0);
`ifdef HUB75_RX_STATS_EN
    check("len_err_cnt", 36'(o_len_err_cnt), 36'd1);
`endif
    push_row(12, 128);
    wr0 = n_wr;
    send_row(12);
    wait_drain("drain_len_err");
    check("len_err_next_writes", 36'(n_wr - wr0), 36'd128);

    // Row select 4 -> 7 after plane 3.
    pulse_rst();
    fill_pat(4, 9);
    for (int k = 0; k < 4; k++) send_plane(k, 4, 64);
    repeat (6) @(negedge clk);
    #1;
    check("row_chg_pre_err", 36'(o_err), 36'd0);
    fill_pat(7, 21);
    push_row(7, 128);
    wr0 = n_wr;
    send_plane(0, 7, 64);
    repeat (6) @(negedge clk);
    #1;
    check("row_chg_err", 36'(o_err), 36'd1);
    for (int k = 1; k < 8; k++) send_plane(k, 7, 64);
    wait_drain("drain_row_chg");
    check("row_chg_writes", 36'(n_wr - wr0), 36'd128);
`ifdef HUB75_RX_STATS_EN
    check("row_err_cnt", 36'(o_row_err_cnt), 36'd1);
`endif

    // Latch during FLUSH.
    pulse_rst();
    fill_pat(9, 5);
    push_row(9, 128);
    wr0 = n_wr;
    send_row(9);
    repeat (10) @(negedge clk);
    i_stb = 1'b1;
    #20 i_stb = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("overrun_err", 36'(o_err), 36'd1);
    wait_drain("drain_overrun");
    check("overrun_writes", 36'(n_wr - wr0), 36'd128);
`ifdef HUB75_RX_STATS_EN
    check("overrun_cnt", 36'(o_overrun_cnt), 36'd1);
`endif

    // Reset after 40 writes of a FLUSH.
    pulse_rst();
    fill_pat(20, 7);
    push_row(20, 40);
    wr0 = n_wr;
    send_row(20);
    for (int i = 0; i < 3000 && (n_wr - wr0) < 40; i++) begin
      @(negedge clk);
      #1;
    end
    check("rst_mid_reached_40", 36'(n_wr - wr0), 36'd40);
    rst = 1'b1;
    #1;
    check("rst_mid_wr_en", 36'(o_wr_en), 36'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("rst_mid_writes", 36'(n_wr - wr0), 36'd40);
    check("rst_mid_sb_empty", 36'(sb.size()), 36'd0);
    fill_pat(21, 13);
    push_row(21, 128);
    wr0 = n_wr;
    send_row(21);
    wait_drain("drain_after_rst");
    check("after_rst_writes", 36'(n_wr - wr0), 36'd128);
    check("after_rst_err",    36'(o_err),      36'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
